lsu: RTL and testbench

- Load/store unit directly downstream of the ALU in the execute/memory path.
- Takes the ALU result as the effective address, issues one request at a time to the data-memory port over a valid/ready handshake, and formats store data and byte enables.
- Aligns and sign/zero-extends load data and delivers a registered writeback result.
- Holds the pipeline via in_ready while a memory operation is outstanding.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/load_align.sv | 33 +++
 rtl/lsu.sv | 129 ++++++++++++
 tb/tb_lsu.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: load/store funct3 encodings, LSU states and
// access-size helpers used by the LSU and its load alignment logic.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} lsu_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_t;

  // Undefined encodings (011, 110, 111) behave as a full word.
  function automatic mem_size_t f3_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (f3_size(funct3))
      SZ_H:    return offset[0];
      SZ_W:    return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
// Purely combinational; shared by every path that returns load data.
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        is_unsigned;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lane_byte   = rdata[{addr, 3'b000} +: 8];
    lane_half   = rdata[{addr[1], 4'b0000} +: 16];
    is_unsigned = funct3[2];
    data        = rdata;
    case (f3_size(funct3))
      SZ_B:    data = is_unsigned ? {{(XLEN-8){1'b0}}, lane_byte}
                                  : {{(XLEN-8){lane_byte[7]}}, lane_byte};
      SZ_H:    data = is_unsigned ? {{(XLEN-16){1'b0}}, lane_half}
                                  : {{(XLEN-16){lane_half[15]}}, lane_half};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op at a time from execute, drives the
// data-memory handshake and returns a registered, extended load result.
module lsu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_store,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [4:0]      in_rd,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_we,
  output logic [3:0]      mem_req_wstrb,
  output logic [XLEN-1:0] mem_req_wdata,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            st_done,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr
);

  lsu_state_t      state, state_next;
  logic [XLEN-1:0] op_addr;
  logic [XLEN-1:0] op_wdata;
  logic [2:0]      op_funct3;
  logic            op_store;
  logic [4:0]      op_rd;
  logic            accept;
  logic            accept_misaligned;
  logic [XLEN-1:0] load_data;

  assign accept            = in_valid && in_ready;
  assign accept_misaligned = accept && is_misaligned(in_funct3, in_addr[1:0]);

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (mem_rsp_rdata),
    .addr   (op_addr[1:0]),
    .funct3 (op_funct3),
    .data   (load_data)
  );

  always_comb begin
    state_next    = state;
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = {op_addr[XLEN-1:2], 2'b00};
    mem_req_we    = op_store;
    mem_req_wstrb = 4'b0000;
    mem_req_wdata = op_wdata;

    // Request fields come only from latched state, so they hold until the handshake.
    if (op_store) begin
      case (f3_size(op_funct3))
        SZ_B: begin
          mem_req_wstrb = 4'b0001 << op_addr[1:0];
          mem_req_wdata = {4{op_wdata[7:0]}};
        end
        SZ_H: begin
          mem_req_wstrb = 4'b0011 << op_addr[1:0];
          mem_req_wdata = {2{op_wdata[15:0]}};
        end
        default: mem_req_wstrb = 4'b1111;
      endcase
    end

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept && !accept_misaligned) state_next = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = op_store ? IDLE : WAIT_RSP;
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      op_addr       <= '0;
      op_wdata      <= '0;
      op_funct3     <= F3_W;
      op_store      <= 1'b0;
      op_rd         <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      st_done       <= 1'b0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      state    <= state_next;
      misalign <= accept_misaligned;
      st_done  <= (state == REQ) && mem_req_ready && op_store;
      wb_valid <= (state == WAIT_RSP) && mem_rsp_valid;

      if (accept) begin
        op_addr   <= in_addr;
        op_wdata  <= in_wdata;
        op_funct3 <= in_funct3;
        op_store  <= in_is_store;
        op_rd     <= in_rd;
      end
      if (accept_misaligned) misalign_addr <= in_addr;
      if ((state == WAIT_RSP) && mem_rsp_valid) begin
        wb_data <= load_data;
        wb_rd   <= op_rd;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: vector table of load/store ops against a zero/variable-wait
// memory, with a queue of expected result pulses, plus reset corner cases.
module tb_lsu;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [3:0]  mem_req_wstrb;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        st_done;
  logic        misalign;
  logic [31:0] misalign_addr;

  lsu #(.XLEN(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_is_store   (in_is_store),
    .in_funct3     (in_funct3),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .in_rd         (in_rd),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_we    (mem_req_we),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .st_done       (st_done),
    .misalign      (misalign),
    .misalign_addr (misalign_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_res;
    logic        exp_mis;
    int          stall;
  } vec_t;

  // kind: 0 = load writeback, 1 = store done, 2 = misalign trap
  typedef struct {
    int          kind;
    logic [31:0] data;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[17];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every result pulse must match the oldest expectation, on its due cycle.
  always @(negedge clk) begin
    if (wb_valid === 1'b1 || st_done === 1'b1 || misalign === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'({wb_valid, st_done, misalign}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", 32'({wb_valid, st_done, misalign}),
              (mon_e.kind == 0) ? 32'd4 : (mon_e.kind == 1) ? 32'd2 : 32'd1);
        check("pulse_cycle", 32'(cyc), 32'(mon_e.due));
        if (mon_e.kind == 0) begin
          check("wb_data", wb_data, mon_e.data);
          check("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
        end else if (mon_e.kind == 2) begin
          check("misalign_addr", misalign_addr, mon_e.data);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   a;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_is_store = v.is_store;
    in_funct3   = v.f3;
    in_addr     = v.addr;
    in_wdata    = v.wdata;
    in_rd       = v.rd;
    a           = cyc;
    e.kind      = v.exp_mis ? 2 : (v.is_store ? 1 : 0);
    e.data      = v.exp_mis ? v.addr : v.exp_res;
    e.rd        = v.rd;
    e.due       = v.exp_mis ? a + 1 : (v.is_store ? a + 2 + v.stall : a + 3 + v.stall);
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    in_addr  = $urandom;
    in_wdata = $urandom;
    if (v.exp_mis) begin
      check("no_req_on_misalign", 32'(mem_req_valid), 32'd0);
      check("in_ready_after_misalign", 32'(in_ready), 32'd1);
    end else begin
      for (int s = 0; s <= v.stall; s++) begin
        mem_req_ready = (s == v.stall);
        check("req_valid", 32'(mem_req_valid), 32'd1);
        check("req_addr", mem_req_addr, v.exp_addr);
        check("req_we", 32'(mem_req_we), 32'(v.is_store));
        check("req_wstrb", 32'(mem_req_wstrb), 32'(v.exp_wstrb));
        if (v.is_store) check("req_wdata", mem_req_wdata, v.exp_wdata);
        check("in_ready_busy", 32'(in_ready), 32'd0);
        @(negedge clk);
      end
      mem_req_ready = 1'b0;
      if (!v.is_store) begin
        check("req_dropped_in_wait", 32'(mem_req_valid), 32'd0);
        check("in_ready_wait", 32'(in_ready), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = v.rdata;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = $urandom;
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_is_store   = 1'b0;
    in_funct3     = F3_W;
    in_addr       = '0;
    in_wdata      = '0;
    in_rd         = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;

    //          st    f3      addr     wdata         rdata         rd   req_addr  strb     req_wdata     result        mis  stall
    vecs[0]  = '{1'b0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 5'd5,  32'h100, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b0, 0};
    vecs[1]  = '{1'b0, F3_B,  32'h103, 32'h0,        32'h80FF7F01, 5'd6,  32'h100, 4'b0000, 32'h0,        32'hFFFFFF80, 1'b0, 0};
    vecs[2]  = '{1'b0, F3_BU, 32'h103, 32'h0,        32'h80FF7F01, 5'd7,  32'h100, 4'b0000, 32'h0,        32'h00000080, 1'b0, 0};
    vecs[3]  = '{1'b0, F3_H,  32'h102, 32'h0,        32'h80FF7F01, 5'd8,  32'h100, 4'b0000, 32'h0,        32'hFFFF80FF, 1'b0, 0};
    vecs[4]  = '{1'b0, F3_HU, 32'h102, 32'h0,        32'h80FF7F01, 5'd9,  32'h100, 4'b0000, 32'h0,        32'h000080FF, 1'b0, 0};
    vecs[5]  = '{1'b0, F3_B,  32'h101, 32'h0,        32'h80FF7F01, 5'd10, 32'h100, 4'b0000, 32'h0,        32'h0000007F, 1'b0, 0};
    vecs[6]  = '{1'b0, F3_H,  32'h100, 32'h0,        32'h80FF7F01, 5'd11, 32'h100, 4'b0000, 32'h0,        32'h00007F01, 1'b0, 0};
    vecs[7]  = '{1'b1, F3_H,  32'h206, 32'h0000ABCD, 32'h0,        5'd0,  32'h204, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0, 0};
    vecs[8]  = '{1'b0, F3_W,  32'h101, 32'h0,        32'h0,        5'd12, 32'h0,   4'b0000, 32'h0,        32'h0,        1'b1, 0};
    vecs[9]  = '{1'b1, F3_B,  32'h001, 32'h0000005A, 32'h0,        5'd0,  32'h000, 4'b0010, 32'h5A5A5A5A, 32'h0,        1'b0, 3};
    vecs[10] = '{1'b1, F3_W,  32'h308, 32'h12345678, 32'h0,        5'd0,  32'h308, 4'b1111, 32'h12345678, 32'h0,        1'b0, 0};
    vecs[11] = '{1'b0, F3_H,  32'h103, 32'h0,        32'h0,        5'd13, 32'h0,   4'b0000, 32'h0,        32'h0,        1'b1, 0};
    vecs[12] = '{1'b1, F3_H,  32'h201, 32'h1111,     32'h0,        5'd0,  32'h0,   4'b0000, 32'h0,        32'h0,        1'b1, 0};
    vecs[13] = '{1'b0, 3'b011,32'h10C, 32'h0,        32'hCAFEF00D, 5'd14, 32'h10C, 4'b0000, 32'h0,        32'hCAFEF00D, 1'b0, 0};
    vecs[14] = '{1'b0, 3'b111,32'h10E, 32'h0,        32'h0,        5'd15, 32'h0,   4'b0000, 32'h0,        32'h0,        1'b1, 0};
    vecs[15] = '{1'b0, F3_W,  32'h040, 32'h0,        32'h11223344, 5'd16, 32'h040, 4'b0000, 32'h0,        32'h11223344, 1'b0, 2};
    vecs[16] = '{1'b1, F3_B,  32'h003, 32'hFFFFFF9C, 32'h0,        5'd0,  32'h000, 4'b1000, 32'h9C9C9C9C, 32'h0,        1'b0, 0};

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_pulses", 32'({wb_valid, st_done, misalign}), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_misalign_addr", misalign_addr, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Responses while idle are ignored; writeback fields hold the last load.
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h0BADF00D;
    repeat (2) @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("idle_rsp_no_wb", 32'(wb_valid), 32'd0);
    check("wb_data_hold", wb_data, 32'h11223344);
    check("wb_rd_hold", 32'(wb_rd), 32'd16);

    // Reset while waiting for a load response; the late response must be dropped.
    @(negedge clk);
    in_valid = 1'b1; in_is_store = 1'b0; in_funct3 = F3_W; in_addr = 32'h100; in_rd = 5'd3;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstw_req_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("rstw_in_wait", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h55555555;
    check("rstw_idle", 32'(in_ready), 32'd1);
    check("rstw_wb_cleared", wb_data, 32'd0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("rstw_no_wb", 32'(wb_valid), 32'd0);
    check("rstw_still_idle", 32'(in_ready), 32'd1);
    check("rstw_no_req", 32'(mem_req_valid), 32'd0);

    // Reset while a store request is stalled; no st_done may follow.
    @(negedge clk);
    in_valid = 1'b1; in_is_store = 1'b1; in_funct3 = F3_W; in_addr = 32'h080; in_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstr_req_valid", 32'(mem_req_valid), 32'd1);
    reset = 1'b1;
    mem_req_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mem_req_ready = 1'b0;
    check("rstr_no_req", 32'(mem_req_valid), 32'd0);
    check("rstr_idle", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    check("rstr_no_st_done", 32'(st_done), 32'd0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
